// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch block.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    IF_STATE_BOOT = 2'd0,
    IF_STATE_RUN  = 2'd1,
    IF_STATE_HALT = 2'd2
  } if_state_e;

  localparam int unsigned PC_INC        = 4;
  localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus: instruction memory read port, redirect input and decode handshake.
interface instruction_fetch_if #(
  parameter int unsigned DATA_BITS = 32
);
  logic [DATA_BITS-1:0] imem_index;
  logic [DATA_BITS-1:0] imem_instruction;
  logic                 redirect_valid;
  logic [DATA_BITS-1:0] redirect_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_instruction;
  logic [DATA_BITS-1:0] out_pc;
  logic                 fetch_err;

  // Fetch unit side
  modport master (
    output imem_index, out_valid, out_instruction, out_pc, fetch_err,
    input  imem_instruction, redirect_valid, redirect_pc, out_ready
  );

  // Memory / decode / branch side
  modport slave (
    input  imem_index, out_valid, out_instruction, out_pc, fetch_err,
    output imem_instruction, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instruction_fetch_next_pc.sv
// Next-PC priority mux and instruction-memory word index generation.
module instruction_fetch_next_pc
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned          DATA_BITS = 32,
  parameter int unsigned          IMEM_SIZE = 128,
  parameter logic [DATA_BITS-1:0] RESET_PC  = '0
) (
  input  if_state_e            state,
  input  logic [DATA_BITS-1:0] resp_pc,
  input  logic                 redirect_valid,
  input  logic [DATA_BITS-1:0] redirect_pc,
  input  logic                 accept,
  output logic [DATA_BITS-1:0] nf_c,
  output logic [DATA_BITS-1:0] index_c
);

  logic aligned;
  assign aligned = (redirect_pc[1:0] & PC_ALIGN_MASK) == 2'b00;

  // Priority: boot, halt hold, aligned redirect, accept advance, stall re-read
  always_comb begin
    nf_c = resp_pc;
    if (state == IF_STATE_BOOT) begin
      nf_c = RESET_PC;
    end else if (state == IF_STATE_HALT) begin
      nf_c = resp_pc;
    end else if (redirect_valid && aligned) begin
      nf_c = redirect_pc;
    end else if (accept) begin
      nf_c = resp_pc + DATA_BITS'(PC_INC);
    end
  end

  // Word index wraps modulo the memory depth
  assign index_c = (nf_c >> 2) & DATA_BITS'(IMEM_SIZE - 1);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC tracking, imem addressing and decode handshake.
// Optional build macro INSTRUCTION_FETCH_PERF_EN adds perf_fetched/perf_stalls counters.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned          DATA_BITS = 32,
  parameter int unsigned          IMEM_SIZE = 128,
  parameter logic [DATA_BITS-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef INSTRUCTION_FETCH_PERF_EN
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stalls,
`endif
  instruction_fetch_if.master  bus
);

  if_state_e            state, state_d;
  logic [DATA_BITS-1:0] resp_pc;
  logic                 err_q, err_d;
  logic [DATA_BITS-1:0] nf_c;
  logic [DATA_BITS-1:0] index_c;
  logic                 valid_c;
  logic                 accept_c;
  logic                 misaligned_c;

  assign valid_c      = (state == IF_STATE_RUN) && !bus.redirect_valid;
  assign accept_c     = valid_c && bus.out_ready;
  assign misaligned_c = bus.redirect_valid && ((bus.redirect_pc[1:0] & PC_ALIGN_MASK) != 2'b00);

  instruction_fetch_next_pc #(
    .DATA_BITS (DATA_BITS),
    .IMEM_SIZE (IMEM_SIZE),
    .RESET_PC  (RESET_PC)
  ) u_next_pc (
    .state          (state),
    .resp_pc        (resp_pc),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .accept         (accept_c),
    .nf_c           (nf_c),
    .index_c        (index_c)
  );

  // State, response PC and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IF_STATE_BOOT;
      resp_pc <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      resp_pc <= nf_c;
      err_q   <= err_d;
    end
  end

  // Next state: boot for one cycle, halt on a misaligned redirect
  always_comb begin
    state_d = state;
    err_d   = err_q;
    case (state)
      IF_STATE_BOOT: state_d = IF_STATE_RUN;
      IF_STATE_RUN: begin
        if (misaligned_c) begin
          state_d = IF_STATE_HALT;
          err_d   = 1'b1;
        end
      end
      IF_STATE_HALT: state_d = IF_STATE_HALT;
      default:       state_d = IF_STATE_BOOT;
    endcase
  end

  assign bus.imem_index      = index_c;
  assign bus.out_valid       = valid_c;
  assign bus.out_pc          = resp_pc;
  assign bus.out_instruction = bus.imem_instruction;
  assign bus.fetch_err       = err_q;

`ifdef INSTRUCTION_FETCH_PERF_EN
  // Saturating accept and stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else begin
      if (accept_c && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (valid_c && !bus.out_ready && (perf_stalls != '1)) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch with a 1-cycle synchronous instruction ROM.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if #(.DATA_BITS(32)) bus ();

`ifdef INSTRUCTION_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
`endif

  instruction_fetch #(
    .DATA_BITS (32),
    .IMEM_SIZE (128),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef INSTRUCTION_FETCH_PERF_EN
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls),
`endif
    .bus          (bus)
  );

  // Instruction ROM: word i holds i, read data one cycle after the index
  logic [31:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = 32'(i);
  always @(posedge clk) bus.imem_instruction <= mem[bus.imem_index[6:0]];

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] index;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare each cycle's outputs against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("out_valid", 32'(bus.out_valid), 32'(e.valid));
      chk("out_pc", bus.out_pc, e.pc);
      chk("imem_index", bus.imem_index, e.index);
      chk("fetch_err", 32'(bus.fetch_err), 32'(e.err));
      if (e.valid) chk("out_instruction", bus.out_instruction, (e.pc >> 2) & 32'd127);
    end
  end

  // One cycle of stimulus plus its expected outputs
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic ev, input logic [31:0] epc, input logic [31:0] eidx,
                      input logic eerr);
    exp_t e;
    @(posedge clk); #1;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    e.valid = ev; e.pc = epc; e.index = eidx; e.err = eerr;
    exp_q.push_back(e);
  endtask

  // Called just after an edge: assert reset asynchronously, release on the next edge
  task automatic do_reset();
    exp_t e;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
`ifdef INSTRUCTION_FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_stalls", perf_stalls, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    e.valid = 1'b0; e.pc = 32'h0; e.index = 32'h0; e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    @(posedge clk); #1;
    do_reset();                                        // boot cycle
    // Sequential fetch with a 3-cycle stall at pc 8
    step(1, 0, 0, 1, 32'h00, 1, 0);
    step(1, 0, 0, 1, 32'h04, 2, 0);
    step(0, 0, 0, 1, 32'h08, 2, 0);
    step(0, 0, 0, 1, 32'h08, 2, 0);
    step(0, 0, 0, 1, 32'h08, 2, 0);
    step(1, 0, 0, 1, 32'h08, 3, 0);
    step(1, 0, 0, 1, 32'h0C, 4, 0);
    step(1, 0, 0, 1, 32'h10, 5, 0);
    // Redirect to 0x40 with ready high: slot squashed
    step(1, 1, 32'h40, 0, 32'h14, 16, 0);
    step(1, 0, 0, 1, 32'h40, 17, 0);
    step(1, 0, 0, 1, 32'h44, 18, 0);
    step(1, 0, 0, 1, 32'h48, 19, 0);
    // Index wrap at the top of memory
    step(1, 1, 32'h1FC, 0, 32'h4C, 127, 0);
    step(1, 0, 0, 1, 32'h1FC, 0, 0);
    step(1, 0, 0, 1, 32'h200, 1, 0);
    // PC wrap around 2^32
    step(1, 1, 32'hFFFF_FFFC, 0, 32'h204, 127, 0);
    step(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step(1, 0, 0, 1, 32'h0, 1, 0);
    // Misaligned redirect halts with sticky error
    step(1, 1, 32'h42, 0, 32'h04, 1, 0);
    step(1, 0, 0, 0, 32'h04, 1, 1);
    step(1, 1, 32'h80, 0, 32'h04, 1, 1);
    step(1, 0, 0, 0, 32'h04, 1, 1);
    @(posedge clk); #1;
    do_reset();
    // Restart, redirect while pc 4, then stalls for the counters
    step(1, 0, 0, 1, 32'h00, 1, 0);
    step(1, 1, 32'h40, 0, 32'h04, 16, 0);
    step(1, 0, 0, 1, 32'h40, 17, 0);
    step(1, 0, 0, 1, 32'h44, 18, 0);
    step(0, 0, 0, 1, 32'h48, 18, 0);
    step(0, 0, 0, 1, 32'h48, 18, 0);
    step(1, 0, 0, 1, 32'h48, 19, 0);
    step(1, 0, 0, 1, 32'h4C, 20, 0);
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
`ifdef INSTRUCTION_FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd5);
    chk("perf_stalls", perf_stalls, 32'd2);
`endif
    do_reset();                                        // asynchronous mid-stream reset
    step(1, 0, 0, 1, 32'h00, 1, 0);
    step(1, 0, 0, 1, 32'h04, 2, 0);
    @(negedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
